instr_fetch_unit: RTL

//   Requester side of the byte-wide instruction memory segment.
//   - Drives sequential byte addresses and assembles INSTRUCTIONWIDTH-bit instructions, first byte in the MSBs.
//   - Buffers assembled instructions in a small FIFO and hands them to decode with a valid/ready handshake.
//   - Accepts a redirect (branch/jump) that flushes all in-flight work and restarts fetch at a new PC.

---
 rtl/instr_fetch_unit.sv | 119 +++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch requester: streams byte reads from the instruction segment,
// assembles multi-byte instructions and buffers them for decode.
//
// state   | meaning
// S_ISSUE | issuing byte addresses pc+byte_idx on consecutive cycles
// S_WAIT  | parked at byte 0, no buffer slot free for a new instruction
module instr_fetch_unit #(
   parameter int WIDTH            = 8,
   parameter int INSTRUCTIONWIDTH = 24,
   parameter int FIFO_DEPTH       = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   output logic [WIDTH-1:0]            mem_addr,
   output logic                        mem_re,
   input  logic [WIDTH-1:0]            mem_rdata,
   input  logic                        redirect,
   input  logic [WIDTH-1:0]            redirect_pc,
   output logic                        instr_valid,
   input  logic                        instr_ready,
   output logic [INSTRUCTIONWIDTH-1:0] instr,
   output logic [WIDTH-1:0]            instr_pc
);

   localparam int BYTES = INSTRUCTIONWIDTH / WIDTH;
   localparam int BIW   = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW    = $clog2(FIFO_DEPTH + 1);

   typedef enum logic {S_ISSUE, S_WAIT} state_t;

   state_t                      state;
   logic [WIDTH-1:0]            pc;
   logic [BIW-1:0]              byte_idx;
   logic                        pending;
   logic                        pend_last;
   logic                        assembling;
   logic [INSTRUCTIONWIDTH-1:0] asm_data;
   logic [WIDTH-1:0]            asm_pc;
   logic [INSTRUCTIONWIDTH-1:0] fifo_data [FIFO_DEPTH];
   logic [WIDTH-1:0]            fifo_pc   [FIFO_DEPTH];
   logic [PW-1:0]               rd_ptr;
   logic [PW-1:0]               wr_ptr;
   logic [CW-1:0]               count;

   logic [CW:0]                 used;
   logic                        slot_ok;
   logic                        issue;
   logic                        last_idx;
   logic                        push;
   logic                        pop;
   logic                        valid_int;
   logic [INSTRUCTIONWIDTH-1:0] shifted;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // An instruction in assembly already owns a slot; a same-cycle pop is not credited.
   assign used      = {1'b0, count} + {{CW{1'b0}}, assembling};
   assign slot_ok   = used < (CW+1)'(FIFO_DEPTH);
   assign issue     = (byte_idx != '0) || slot_ok;
   assign last_idx  = (byte_idx == BIW'(BYTES - 1));
   assign shifted   = (asm_data << WIDTH) | INSTRUCTIONWIDTH'(mem_rdata);
   assign push      = pending && pend_last;
   assign valid_int = (count != '0);
   assign pop       = valid_int && instr_ready;

   assign mem_re      = issue && !reset;
   assign mem_addr    = reset ? '0 : ((state == S_WAIT) ? pc : pc + WIDTH'(byte_idx));
   assign instr_valid = valid_int && !reset;
   assign instr       = reset ? '0 : fifo_data[rd_ptr];
   assign instr_pc    = reset ? '0 : fifo_pc[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset || redirect) begin
         state      <= S_ISSUE;
         pc         <= reset ? '0 : redirect_pc;
         byte_idx   <= '0;
         pending    <= 1'b0;
         pend_last  <= 1'b0;
         assembling <= 1'b0;
         asm_data   <= '0;
         asm_pc     <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_data[i] <= '0;
            fifo_pc[i]   <= '0;
         end
      end else begin
         state   <= issue ? S_ISSUE : S_WAIT;
         pending <= issue;
         if (issue) begin
            pend_last <= last_idx;
            if (byte_idx == '0) asm_pc <= pc;
            if (last_idx) begin
               byte_idx <= '0;
               pc       <= pc + WIDTH'(BYTES);
            end else begin
               byte_idx <= byte_idx + BIW'(1);
            end
         end
         if (issue && byte_idx == '0) assembling <= 1'b1;
         else if (push)               assembling <= 1'b0;
         if (pending) asm_data <= shifted;
         if (push) begin
            fifo_data[wr_ptr] <= shifted;
            fifo_pc[wr_ptr]   <= asm_pc;
            wr_ptr            <= ptr_inc(wr_ptr);
         end
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
      end
   end

endmodule
